shared_mem_arb: RTL and testbench

Parametrised successor to the team's single-port on-chip shared memory. Provides NUM_PORTS independent Avalon-MM slave ports onto one synchronous RAM array, with round-robin arbitration, waitrequest back-pressure and pipelined readdatavalid. Sits between the SoC interconnect and the masters (CPUs, DMA) that exchange data through shared memory.

---
 rtl/shared_mem_pkg.sv | 30 +++
 rtl/shared_mem_rr_arb.sv | 60 ++++++
 rtl/shared_mem_arb.sv | 173 +++++++++++++++++
 tb/tb_shared_mem_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_pkg.sv
// shared_mem_pkg
// Shared constants and types for the multi-port shared memory.
//   DEF_*       default geometry used by shared_mem_arb
//   RD_LAT      read latency in cycles: 2 when SHARED_MEM_OUTREG_EN is defined, else 1
//   acc_e       kind of access the arbiter granted this cycle
//   idx_w()     width of a port / word index (minimum 1 bit)
package shared_mem_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_DEPTH     = 16380;
  localparam int DEF_NUM_PORTS = 2;

`ifdef SHARED_MEM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_rr_arb.sv
// shared_mem_rr_arb
// Round-robin arbiter: at most one grant per cycle, priority starting at the
// port after the last granted one. The pointer only moves on a grant, and
// resets to NUM_PORTS-1 so that port 0 has priority first.
//   clk, reset   clock, synchronous active-high reset
//   req          per-port request vector
//   grant        one-hot grant
//   grant_idx    encoded index of the granted port
//   grant_valid  a grant was issued this cycle
module shared_mem_rr_arb
  import shared_mem_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  localparam int IDX_W    = idx_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int               cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else if (grant_valid) begin
      last_grant <= grant_idx;
    end
  end

  // last_grant + 1 + k never exceeds 2*NUM_PORTS-1, so one wrap is enough.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(last_grant) + 1 + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        found           = 1'b1;
      end
    end
  end

  assign grant_valid = |req;

endmodule

// File: rtl/shared_mem_arb.sv
// shared_mem_arb
// NUM_PORTS Avalon-MM slave ports sharing one synchronous RAM. One access is
// granted per cycle (round robin); losers see waitrequest and hold. Reads
// return on the requesting port with readdatavalid after the read latency.
// Optional feature macro: SHARED_MEM_OUTREG_EN adds a register stage after
// the RAM output and tag (read latency 2 instead of 1, same throughput).
//   clk, reset     clock, synchronous active-high reset
//   address        per-port word address, port i at slice i
//   byteenable     per-port byte lanes
//   chipselect     per-port select
//   read, write    per-port requests (both high counts as a write)
//   writedata      per-port write data
//   readdata       per-port read data, holds last value between pulses
//   readdatavalid  per-port one-cycle pulse per completed read
//   waitrequest    per-port: request not accepted this cycle
//   oob_err        sticky: some access used address >= DEPTH
module shared_mem_arb
  import shared_mem_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    ADDR_W    = DEF_ADDR_W,
  parameter int    DEPTH     = DEF_DEPTH,
  parameter int    NUM_PORTS = DEF_NUM_PORTS,
  parameter string INIT_FILE = "shared_mem.hex"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*ADDR_W-1:0]   address,
  input  logic [NUM_PORTS*DATA_W/8-1:0] byteenable,
  input  logic [NUM_PORTS-1:0]          chipselect,
  input  logic [NUM_PORTS-1:0]          read,
  input  logic [NUM_PORTS-1:0]          write,
  input  logic [NUM_PORTS*DATA_W-1:0]   writedata,
  output logic [NUM_PORTS*DATA_W-1:0]   readdata,
  output logic [NUM_PORTS-1:0]          readdatavalid,
  output logic [NUM_PORTS-1:0]          waitrequest,
  output logic                          oob_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = idx_w(NUM_PORTS);
  localparam int MEM_AW = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Request / arbitration
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] req_arb;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     gidx;
  logic                 gvalid;

  assign req     = chipselect & (read | write);
  // Nothing is accepted while reset is high, so the pointer cannot move then.
  assign req_arb = reset ? '0 : req;

  shared_mem_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req_arb),
    .grant       (grant),
    .grant_idx   (gidx),
    .grant_valid (gvalid)
  );

  assign waitrequest = {NUM_PORTS{reset}} | (req & ~grant);

  // Granted port's command
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [MEM_AW-1:0] mem_idx;
  logic              sel_oob;
  acc_e              acc;

  always_comb begin
    sel_addr  = address[int'(gidx)*ADDR_W +: ADDR_W];
    sel_be    = byteenable[int'(gidx)*BE_W +: BE_W];
    sel_wdata = writedata[int'(gidx)*DATA_W +: DATA_W];
    sel_oob   = ({1'b0, sel_addr} >= DEPTH_L);
    mem_idx   = sel_addr[MEM_AW-1:0];
    acc       = ACC_NONE;
    if (gvalid) begin
      acc = write[gidx] ? ACC_WRITE : ACC_READ;
    end
  end

  // RAM write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (acc == ACC_WRITE && !sel_oob) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  // RAM read port with its tag. Only one access per cycle, so a read never
  // collides with a write in the same edge; a write on the previous accept
  // is already in the array, which gives write-first behaviour.
  logic [DATA_W-1:0] ram_q;
  logic              tag_v;
  logic [IDX_W-1:0]  tag_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_q   <= '0;
      tag_v   <= 1'b0;
      tag_idx <= '0;
    end else begin
      tag_v   <= (acc == ACC_READ);
      tag_idx <= gidx;
      if (acc == ACC_READ) begin
        ram_q <= sel_oob ? '0 : mem[mem_idx];
      end
    end
  end

  logic [DATA_W-1:0] out_q;
  logic              out_v;
  logic [IDX_W-1:0]  out_idx;

`ifdef SHARED_MEM_OUTREG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      out_v   <= 1'b0;
      out_idx <= '0;
    end else begin
      out_q   <= ram_q;
      out_v   <= tag_v;
      out_idx <= tag_idx;
    end
  end
`else
  assign out_q   = ram_q;
  assign out_v   = tag_v;
  assign out_idx = tag_idx;
`endif

  // Per-port return. The pulse is masked by reset so a read accepted just
  // before reset never completes; hold_q keeps readdata between pulses.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [DATA_W-1:0] hold_q;
    logic              hit;

    assign hit = out_v & ~reset & (out_idx == IDX_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_q <= '0;
      end else if (hit) begin
        hold_q <= out_q;
      end
    end

    assign readdatavalid[i]              = hit;
    assign readdata[i*DATA_W +: DATA_W]  = hit ? out_q : hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oob_err <= 1'b0;
    end else if (acc != ACC_NONE && sel_oob) begin
      oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_mem_arb.sv
module tb_shared_mem_arb;

  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int DEP = 16380;
  localparam int NP  = 2;
  localparam int BW  = DW / 8;
`ifdef SHARED_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP*AW-1:0]  address = '0;
  logic [NP*BW-1:0]  byteenable = '0;
  logic [NP-1:0]     chipselect = '0;
  logic [NP-1:0]     read = '0;
  logic [NP-1:0]     write = '0;
  logic [NP*DW-1:0]  writedata = '0;
  logic [NP*DW-1:0]  readdata;
  logic [NP-1:0]     readdatavalid;
  logic [NP-1:0]     waitrequest;
  logic              oob_err;

  always #5 clk = ~clk;

  shared_mem_arb #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEP),
    .NUM_PORTS (NP),
    .INIT_FILE ("")
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .oob_err       (oob_err)
  );

  typedef struct {
    bit            cs;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  op_t           opq [NP][$];
  exp_t          sbq [$];
  logic [DW-1:0] mdl [int];
  int            tb_last = NP - 1;
  bit            oob_m = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every readdatavalid pulse must match the oldest expected read.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        if (readdatavalid[p]) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL rdv_unexpected port=%0d cyc=%0d got=%h", p, cyc, readdata[p*DW +: DW]);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || e.due != cyc || readdata[p*DW +: DW] !== e.data) begin
              failures++;
              $display("FAIL rd_data port=%0d/%0d cyc=%0d/%0d got=%h exp=%h",
                       p, e.port, cyc, e.due, readdata[p*DW +: DW], e.data);
            end
          end
        end
      end
      if (sbq.size() != 0 && sbq[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL rdv_missing port=%0d due=%0d cyc=%0d", sbq[0].port, sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
    end
  end

  function automatic op_t mk(bit rd, bit wr, int addr, logic [BW-1:0] be, logic [DW-1:0] data);
    op_t o;
    o.cs   = rd | wr;
    o.rd   = rd;
    o.wr   = wr;
    o.addr = AW'(addr);
    o.be   = be;
    o.data = data;
    return o;
  endfunction

  function automatic op_t idle();
    return mk(1'b0, 1'b0, 0, '0, '0);
  endfunction

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (opq[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Plays the per-port op queues, predicting grants, waitrequest, memory
  // contents and read returns. Starts and ends just after a rising edge.
  task automatic apply_ops(input int max_cyc, input bit drain, output int used);
    logic [NP-1:0] rq;
    logic [NP-1:0] exp_wr;
    int            g;
    int            q;
    op_t           o;
    logic [DW-1:0] w;
    exp_t          e;
    used = 0;
    while (pending() && used < max_cyc) begin
      for (int p = 0; p < NP; p++) begin
        o = (opq[p].size() != 0) ? opq[p][0] : idle();
        chipselect[p]            = o.cs;
        read[p]                  = o.rd;
        write[p]                 = o.wr;
        address[p*AW +: AW]      = o.addr;
        byteenable[p*BW +: BW]   = o.be;
        writedata[p*DW +: DW]    = o.data;
        rq[p]                    = o.cs & (o.rd | o.wr);
      end
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NP; k++) begin
        q = (tb_last + 1 + k) % NP;
        if (g < 0 && rq[q]) g = q;
      end
      exp_wr = rq;
      if (g >= 0) exp_wr[g] = 1'b0;
      checks++;
      if (waitrequest !== exp_wr) begin
        failures++;
        $display("FAIL waitrequest cyc=%0d got=%b exp=%b", cyc, waitrequest, exp_wr);
      end
      if (g >= 0) begin
        o = opq[g][0];
        if (int'(o.addr) >= DEP) oob_m = 1'b1;
        if (o.wr) begin
          if (int'(o.addr) < DEP) begin
            w = mdl.exists(int'(o.addr)) ? mdl[int'(o.addr)] : 'x;
            for (int b = 0; b < BW; b++) if (o.be[b]) w[b*8 +: 8] = o.data[b*8 +: 8];
            mdl[int'(o.addr)] = w;
          end
        end else begin
          e.port = g;
          e.data = (int'(o.addr) < DEP) ? mdl[int'(o.addr)] : '0;
          e.due  = cyc + LAT;
          sbq.push_back(e);
        end
        tb_last = g;
      end
      for (int p = 0; p < NP; p++) begin
        if (opq[p].size() != 0 && (!rq[p] || p == g)) void'(opq[p].pop_front());
      end
      @(posedge clk);
      #1;
      used++;
    end
    if (pending()) begin
      checks++;
      failures++;
      $display("FAIL op_timeout after %0d cycles", used);
      for (int p = 0; p < NP; p++) opq[p].delete();
    end
    chipselect = '0;
    read       = '0;
    write      = '0;
    if (drain) begin
      for (int n = 0; n < LAT + 3 && sbq.size() != 0; n++) begin
        @(posedge clk);
        #1;
      end
      if (sbq.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout left=%0d", sbq.size());
        sbq.delete();
      end
    end
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (n > 0) begin
        checks++;
        if (waitrequest !== '1 || readdatavalid !== '0) begin
          failures++;
          $display("FAIL reset_hold wr=%b rdv=%b exp wr=11 rdv=00", waitrequest, readdatavalid);
        end
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (readdata !== '0 || readdatavalid !== '0 || oob_err !== 1'b0 || waitrequest !== '0) begin
      failures++;
      $display("FAIL reset_state rd=%h rdv=%b oob=%b wr=%b exp all zero",
               readdata, readdatavalid, oob_err, waitrequest);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_then_read();
    int used;
    opq[0].push_back(mk(0, 1, 5, 4'hF, 32'hDEADBEEF));
    opq[1].push_back(idle());
    opq[1].push_back(mk(1, 0, 5, 4'hF, '0));
    apply_ops(10, 1'b1, used);
    checks++;
    if (readdata[DW +: DW] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL raw_hold port1 got=%h exp=deadbeef", readdata[DW +: DW]);
    end
  endtask

  task automatic test_alternate();
    int used;
    for (int i = 0; i < 8; i++) begin
      opq[0].push_back(mk(0, 1, 16 + i, 4'hF, 32'h1111_1111 * (i + 1)));
      opq[1].push_back(mk(1, 0, 16 + i, 4'hF, '0));
    end
    apply_ops(40, 1'b1, used);
    checks++;
    if (used != 16) begin
      failures++;
      $display("FAIL alternate_cycles got=%0d exp=16", used);
    end
  endtask

  task automatic test_byteenable();
    int used;
    opq[0].push_back(mk(0, 1, 3, 4'hF, 32'hFFFFFFFF));
    opq[0].push_back(mk(0, 1, 3, 4'b0010, 32'h0000AB00));
    opq[0].push_back(mk(1, 0, 3, 4'hF, '0));
    opq[0].push_back(mk(0, 1, 3, 4'b0000, 32'h12345678));
    opq[0].push_back(mk(1, 1, 7, 4'hF, 32'hCAFEF00D));
    opq[0].push_back(mk(1, 0, 3, 4'hF, '0));
    opq[1].push_back(mk(1, 0, 7, 4'hF, '0));
    apply_ops(20, 1'b1, used);
    checks++;
    if (readdata[0 +: DW] !== 32'hFFFFABFF) begin
      failures++;
      $display("FAIL byteenable got=%h exp=ffffabff", readdata[0 +: DW]);
    end
  endtask

  task automatic test_oob();
    int used;
    checks++;
    if (oob_err !== 1'b0) begin
      failures++;
      $display("FAIL oob_pre got=%b exp=0", oob_err);
    end
    opq[1].push_back(mk(1, 0, DEP, 4'hF, '0));
    opq[0].push_back(mk(0, 1, DEP + 1, 4'hF, 32'h5555AAAA));
    opq[0].push_back(mk(1, 0, DEP + 1, 4'hF, '0));
    opq[0].push_back(mk(1, 0, 5, 4'hF, '0));
    apply_ops(20, 1'b1, used);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (oob_err !== oob_m) begin
      failures++;
      $display("FAIL oob_sticky got=%b exp=%b", oob_err, oob_m);
    end
  endtask

  task automatic test_back_to_back();
    int used;
    for (int i = 0; i < 4; i++) opq[0].push_back(mk(0, 1, i, 4'hF, 32'hA0A0_0000 + i));
    apply_ops(10, 1'b1, used);
    for (int i = 0; i < 4; i++) opq[0].push_back(mk(1, 0, i, 4'hF, '0));
    apply_ops(10, 1'b1, used);
    checks++;
    if (used != 4) begin
      failures++;
      $display("FAIL b2b_cycles got=%0d exp=4", used);
    end
  endtask

  task automatic test_reset_squash();
    int used;
    opq[0].push_back(mk(1, 0, 16, 4'hF, '0));
    apply_ops(5, 1'b0, used);
    reset = 1'b1;
    sbq.delete();
    chipselect[1] = 1'b1;
    read[1]       = 1'b1;
    address[AW +: AW] = AW'(5);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (readdatavalid !== '0 || waitrequest !== '1) begin
        failures++;
        $display("FAIL reset_squash n=%0d rdv=%b wr=%b exp rdv=00 wr=11", n, readdatavalid, waitrequest);
      end
      @(posedge clk);
      #1;
    end
    chipselect = '0;
    read       = '0;
    reset      = 1'b0;
    tb_last    = NP - 1;
    oob_m      = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (oob_err !== 1'b0 || readdata !== '0 || readdatavalid !== '0) begin
        failures++;
        $display("FAIL post_reset n=%0d oob=%b rd=%h rdv=%b exp all zero", n, oob_err, readdata, readdatavalid);
      end
      @(posedge clk);
      #1;
    end
    opq[1].push_back(mk(1, 0, 5, 4'hF, '0));
    opq[0].push_back(mk(1, 0, 3, 4'hF, '0));
    apply_ops(10, 1'b1, used);
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_alternate();
    test_byteenable();
    test_oob();
    test_back_to_back();
    test_reset_squash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
